// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit scheduler.
package uart_pkg;
  localparam int CLKS_PER_BIT_115200 = 868;
  localparam int FRAME_BITS          = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;
endpackage

// File: rtl/uart_tx_core.sv
// 8N1 frame serializer: latches a byte on start, shifts it out LSB first.
module uart_tx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       serial_out,
  output logic       busy,
  output logic       done
);
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_TOP = TW'(CLKS_PER_BIT - 1);

  tx_state_t      state, state_d;
  logic [TW-1:0]  timer, timer_d;
  logic [2:0]     idx, idx_d;
  logic [7:0]     shift, shift_d;
  logic           serial_d;
  logic           tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      timer      <= '0;
      idx        <= '0;
      shift      <= '0;
      serial_out <= 1'b1;
    end else begin
      state      <= state_d;
      timer      <= timer_d;
      idx        <= idx_d;
      shift      <= shift_d;
      serial_out <= serial_d;
    end
  end

  assign tick = (timer == '0);
  assign busy = (state != IDLE);

  // serial_d is the next line level, so every bit boundary is decided one cycle early
  always_comb begin
    state_d  = state;
    timer_d  = timer;
    idx_d    = idx;
    shift_d  = shift;
    serial_d = serial_out;
    done     = 1'b0;
    case (state)
      IDLE: begin
        serial_d = 1'b1;
        if (start) begin
          state_d  = START;
          timer_d  = BIT_TOP;
          shift_d  = data;
          serial_d = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d  = DATA;
          timer_d  = BIT_TOP;
          idx_d    = 3'd0;
          serial_d = shift[0];
        end else timer_d = timer - 1'b1;
      end
      DATA: begin
        if (tick) begin
          timer_d = BIT_TOP;
          if (idx == 3'd7) begin
            state_d  = STOP;
            serial_d = 1'b1;
          end else begin
            idx_d    = idx + 3'd1;
            shift_d  = shift >> 1;
            serial_d = shift[1];
          end
        end else timer_d = timer - 1'b1;
      end
      STOP: begin
        if (tick) begin
          state_d  = IDLE;
          done     = 1'b1;
          serial_d = 1'b1;
        end else timer_d = timer - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART TX line between NUM_REQ byte producers,
// with per-message line locking and a lock-abandonment timeout.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_115200,
  parameter int LOCK_TIMEOUT = 4096,
  localparam int OW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 serial_out,
  output logic                 busy,
  output logic [OW-1:0]        owner,
  output logic                 locked,
  output logic                 timeout_err
);
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  logic [OW-1:0] ptr, win;
  logic          found, grant, done;
  logic [CW-1:0] lock_cnt;
  logic [7:0]    sel_byte;

  // A locked line only listens to its owner; otherwise scan upward from ptr.
  always_comb begin
    win   = '0;
    found = 1'b0;
    if (locked) begin
      found = req[owner];
      win   = owner;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req[(int'(ptr) + i) % NUM_REQ]) begin
          found = 1'b1;
          win   = OW'((int'(ptr) + i) % NUM_REQ);
        end
      end
    end
  end

  assign grant    = found && !busy;
  assign ack      = grant ? (NUM_REQ'(1) << win) : '0;
  assign sel_byte = req_data[8*win +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      owner       <= '0;
      locked      <= 1'b0;
      timeout_err <= 1'b0;
      lock_cnt    <= '0;
    end else if (grant) begin
      owner    <= win;
      ptr      <= (win == OW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      locked   <= ~req_last[win];
      lock_cnt <= '0;
    end else if (locked && !busy && !req[owner]) begin
      if (lock_cnt == CW'(LOCK_TIMEOUT - 1)) begin
        locked      <= 1'b0;
        timeout_err <= 1'b1;
        lock_cnt    <= '0;
      end else lock_cnt <= lock_cnt + 1'b1;
    end else if (done) begin
      lock_cnt <= '0;
    end
  end

  uart_tx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (grant),
    .data       (sel_byte),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done)
  );
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized bench: queue-driven producers, line decoder and a grant-order model.
module tb_uart_tx_scheduler;
  localparam int N   = 4;
  localparam int CPB = 8;
  localparam int LT  = 32;

  logic           clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]   req = '0, req_last = '1, ack;
  logic [8*N-1:0] req_data = '0;
  logic           serial_out, busy, locked, timeout_err;
  logic [1:0]     owner;

  int checks = 0, errors = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_tx_scheduler #(.NUM_REQ(N), .CLKS_PER_BIT(CPB), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_last(req_last),
    .ack(ack), .serial_out(serial_out), .busy(busy), .owner(owner),
    .locked(locked), .timeout_err(timeout_err)
  );

  // producers: each queue entry is {last, byte}; head is presented until acked
  logic [8:0]   pq[N][$];
  logic [N-1:0] ack_seen = '0, pulse = '0;
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++) begin
      if (ack_seen[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      req[i]           = (pq[i].size() > 0) | pulse[i];
      req_data[8*i+:8] = (pq[i].size() > 0) ? pq[i][0][7:0] : 8'h00;
      req_last[i]      = (pq[i].size() > 0) ? pq[i][0][8] : 1'b1;
    end
    pulse = '0;
  end

  // ack monitor: grant order, grant cycle, and lock state right after each grant
  int   ack_idx_q[$], ack_cyc_q[$];
  logic lock_q[$];
  logic pend = 1'b0;
  always @(negedge clk) begin
    ack_seen = ack;
    if (pend) begin lock_q.push_back(locked); pend = 1'b0; end
    if (ack != '0) begin
      checks++;
      if (!$onehot(ack)) begin errors++; $display("FAIL ack_onehot got %b", ack); end
      for (int i = 0; i < N; i++) if (ack[i]) ack_idx_q.push_back(i);
      ack_cyc_q.push_back(cyc);
      pend = 1'b1;
    end
  end

  // line decoder, sampling mid-bit
  logic [7:0] dec_q[$];
  bit mon_en = 1'b1;
  initial begin : decoder
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n && serial_out === 1'b0) begin
        repeat (CPB/2) @(negedge clk);
        checks++;
        if (serial_out !== 1'b0) begin errors++; $display("FAIL start_bit got %b want 0", serial_out); end
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = serial_out;
        end
        repeat (CPB) @(negedge clk);
        checks++;
        if (serial_out !== 1'b1) begin errors++; $display("FAIL stop_bit got %b want 1", serial_out); end
        if (mon_en) dec_q.push_back(b);
      end
    end
  end

  // reference model: arbitration decisions straight from the rules, over queue snapshots
  int   m_ptr = 0, m_owner = 0;
  bit   m_locked = 0;
  int   exp_idx_q[$];
  logic [7:0] exp_dat_q[$];
  logic exp_lock_q[$];

  task automatic model_run();
    logic [8:0] mq[N][$];
    int w;
    for (int i = 0; i < N; i++) mq[i] = pq[i];
    forever begin
      w = -1;
      if (m_locked) begin
        if (mq[m_owner].size() > 0) w = m_owner;
      end else begin
        for (int k = 0; k < N; k++)
          if (w < 0 && mq[(m_ptr + k) % N].size() > 0) w = (m_ptr + k) % N;
      end
      if (w < 0) break;
      exp_idx_q.push_back(w);
      exp_dat_q.push_back(mq[w][0][7:0]);
      m_locked = !mq[w][0][8];
      exp_lock_q.push_back(m_locked);
      m_owner = w;
      m_ptr   = (w + 1) % N;
      void'(mq[w].pop_front());
    end
  endtask

  task automatic clear_obs();
    ack_idx_q.delete(); ack_cyc_q.delete(); lock_q.delete(); dec_q.delete();
    exp_idx_q.delete(); exp_dat_q.delete(); exp_lock_q.delete();
  endtask

  task automatic check_run(input string name, input bit b2b);
    int n, t;
    n = exp_idx_q.size();
    t = 0;
    while ((ack_idx_q.size() < n || dec_q.size() < n || lock_q.size() < n) && t < n*100 + 200) begin
      @(negedge clk); t++;
    end
    checks++;
    if (ack_idx_q.size() != n || dec_q.size() != n) begin
      errors++;
      $display("FAIL %s_count acks %0d bytes %0d want %0d", name, ack_idx_q.size(), dec_q.size(), n);
    end
    for (int k = 0; k < n; k++) begin
      if (k >= ack_idx_q.size() || k >= dec_q.size() || k >= lock_q.size()) break;
      checks++;
      if (ack_idx_q[k] !== exp_idx_q[k]) begin
        errors++; $display("FAIL %s_grant[%0d] got %0d want %0d", name, k, ack_idx_q[k], exp_idx_q[k]);
      end
      checks++;
      if (dec_q[k] !== exp_dat_q[k]) begin
        errors++; $display("FAIL %s_byte[%0d] got %h want %h", name, k, dec_q[k], exp_dat_q[k]);
      end
      checks++;
      if (lock_q[k] !== exp_lock_q[k]) begin
        errors++; $display("FAIL %s_locked[%0d] got %b want %b", name, k, lock_q[k], exp_lock_q[k]);
      end
      if (b2b && k > 0) begin
        checks++;
        if (ack_cyc_q[k] - ack_cyc_q[k-1] !== 10*CPB + 1) begin
          errors++;
          $display("FAIL %s_spacing[%0d] got %0d want %0d", name, k, ack_cyc_q[k] - ack_cyc_q[k-1], 10*CPB + 1);
        end
      end
    end
    clear_obs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) pq[i].delete();
    pulse = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    m_ptr = 0; m_owner = 0; m_locked = 0;
    clear_obs();
  endtask

  task automatic wait_acks(input int n, input string name);
    int t = 0;
    while (ack_idx_q.size() < n && t < 200) begin @(negedge clk); t++; end
    checks++;
    if (ack_idx_q.size() < n) begin errors++; $display("FAIL %s_ack_wait got %0d acks want %0d", name, ack_idx_q.size(), n); end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({serial_out, busy, ack, owner, locked, timeout_err} !== 10'b1_0_0000_00_0_0) begin
      errors++;
      $display("FAIL reset_vals got %b want %b", {serial_out, busy, ack, owner, locked, timeout_err}, 10'b1000000000);
    end
    do_reset();
  endtask

  task automatic test_single_frame();
    logic [9:0] frame;
    logic [7:0] d = 8'hA5;
    int nb = 0;
    frame = {1'b1, d, 1'b0};
    pq[0].push_back({1'b1, d});
    model_run();
    @(negedge clk);
    checks++;
    if (ack !== 4'b0001) begin errors++; $display("FAIL single_ack got %b want 0001", ack); end
    for (int c = 0; c < 10*CPB; c++) begin
      @(negedge clk);
      checks++;
      if (serial_out !== frame[c/CPB]) begin
        errors++; $display("FAIL single_line cyc %0d got %b want %b", c, serial_out, frame[c/CPB]);
      end
      if (busy === 1'b1) nb++;
    end
    @(negedge clk);
    checks++;
    if (nb !== 10*CPB || busy !== 1'b0 || serial_out !== 1'b1) begin
      errors++; $display("FAIL single_busy got %0d cycles end busy %b want %0d", nb, busy, 10*CPB);
    end
    check_run("single", 0);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < N; i++) pq[i].push_back({1'b1, 8'($urandom)});
    pq[0].push_back({1'b1, 8'($urandom)});
    model_run();
    check_run("rr", 1);
  endtask

  task automatic test_lock_message();
    do_reset();
    pq[1].push_back({1'b0, 8'h11});
    pq[1].push_back({1'b0, 8'h22});
    pq[1].push_back({1'b1, 8'h33});
    pq[2].push_back({1'b1, 8'($urandom)});
    pq[0].push_back({1'b1, 8'($urandom)});
    model_run();
    check_run("lock", 1);
  endtask

  task automatic test_lock_timeout();
    int n = 0, t = 0;
    logic [7:0] d3 = 8'($urandom), d0 = 8'($urandom);
    do_reset();
    pq[3].push_back({1'b0, d3});
    wait_acks(1, "timeout");
    pq[0].push_back({1'b1, d0});
    @(negedge clk);
    checks++;
    if (locked !== 1'b1 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL timeout_pre locked %b err %b want 1 0", locked, timeout_err);
    end
    while (busy === 1'b1 && t < 200) begin @(negedge clk); t++; end
    while (locked === 1'b1 && n < 200) begin n++; @(negedge clk); end
    checks++;
    if (n !== LT) begin errors++; $display("FAIL timeout_len got %0d want %0d", n, LT); end
    checks++;
    if (timeout_err !== 1'b1 || ack !== 4'b0001) begin
      errors++; $display("FAIL timeout_after err %b ack %b want 1 0001", timeout_err, ack);
    end
    exp_idx_q = '{3, 0};
    exp_dat_q = '{d3, d0};
    exp_lock_q = '{1'b1, 1'b0};
    check_run("timeout", 0);
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    pq[0].push_back({1'b1, 8'($urandom)});
    wait_acks(1, "midrst");
    repeat (CPB + 4*CPB + 3) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy got %b want 1", busy); end
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({serial_out, busy, ack, owner, locked, timeout_err} !== 10'b1_0_0000_00_0_0) begin
      errors++;
      $display("FAIL midrst_vals got %b want %b", {serial_out, busy, ack, owner, locked, timeout_err}, 10'b1000000000);
    end
    for (int i = 0; i < N; i++) pq[i].delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12*CPB) @(negedge clk);
    m_ptr = 0; m_owner = 0; m_locked = 0;
    clear_obs();
    mon_en = 1'b1;
    pq[0].push_back({1'b1, 8'($urandom)});
    pq[2].push_back({1'b1, 8'($urandom)});
    model_run();
    check_run("midrst", 1);
  endtask

  task automatic test_req_withdraw();
    int t = 0;
    do_reset();
    pq[1].push_back({1'b1, 8'($urandom)});
    model_run();
    wait_acks(1, "withdraw");
    repeat (3*CPB) @(negedge clk);
    pulse[2] = 1'b1;
    repeat (12*CPB) @(negedge clk);
    checks++;
    if (serial_out !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL withdraw_idle line %b busy %b want 1 0", serial_out, busy);
    end
    check_run("withdraw", 0);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_lock_message();
    test_lock_timeout();
    test_reset_mid_frame();
    test_req_withdraw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end
endmodule
